// File: rtl/eth_txcounters_gen.sv
// Transmit-side beat/byte/deferral counter bank for the Ethernet TX MAC.
// Runtime MII/GMII beat selection, with per-frame good-frame count and last frame length.
module eth_txcounters_gen #(
  parameter int CNT_W       = 16,
  parameter int STAT_W      = 32,
  parameter int PRE_BYTES   = 7,
  parameter int JAM_BYTES   = 4,
  parameter int DEFER_LIMIT = 6071,
  parameter int DLYCRC_LEN  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              gmii_mode_i,
  input  logic [3:0]        tx_state_i,
  input  logic              state_start_i,
  input  logic              start_backoff_i,
  input  logic              start_jam_i,
  input  logic              tx_start_frm_i,
  input  logic              packet_finished_i,
  input  logic              frame_aborted_i,
  input  logic [CNT_W-1:0]  min_fl_i,
  input  logic [CNT_W-1:0]  max_fl_i,
  input  logic              hug_en_i,
  input  logic              ex_dfr_en_i,
  input  logic              dly_crc_en_i,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  byte_cnt_o,
  output logic              field_done_o,
  output logic              excessive_defer_o,
  output logic              max_frame_o,
  output logic              min_frame_met_o,
  output logic [2:0]        dly_crc_cnt_o,
  output logic [STAT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0]  last_len_o
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_DEFER   = 4'd1;
  localparam logic [3:0] ST_PRE     = 4'd3;
  localparam logic [3:0] ST_SFD     = 4'd4;
  localparam logic [3:0] ST_DA      = 4'd5;
  localparam logic [3:0] ST_SA      = 4'd6;
  localparam logic [3:0] ST_LEN     = 4'd7;
  localparam logic [3:0] ST_DATA    = 4'd8;
  localparam logic [3:0] ST_PAD     = 4'd9;
  localparam logic [3:0] ST_FCS     = 4'd10;
  localparam logic [3:0] ST_JAM     = 4'd11;
  localparam logic [3:0] ST_BACKOFF = 4'd12;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  byte_q, byte_d;
  logic [2:0]        dly_q, dly_d;
  logic [STAT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]  last_len_q, last_len_d;

  logic             st_idle, st_defer, st_sfd, st_data, st_backoff;
  logic             byte_strobe, exc_defer, field_done, is_field;
  logic [CNT_W-1:0] field_bytes, field_beats;
  logic [CNT_W+1:0] min_lhs, min_rhs;

  assign st_idle     = (tx_state_i == ST_IDLE);
  assign st_defer    = (tx_state_i == ST_DEFER);
  assign st_sfd      = (tx_state_i == ST_SFD);
  assign st_data     = (tx_state_i == ST_DATA);
  assign st_backoff  = (tx_state_i == ST_BACKOFF);
  assign byte_strobe = gmii_mode_i | beat_q[0];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_field    = 1'b1;
    field_bytes = '0;
    case (tx_state_i)
      ST_PRE:        field_bytes = CNT_W'(PRE_BYTES);
      ST_SFD:        field_bytes = CNT_W'(1);
      ST_DA, ST_SA:  field_bytes = CNT_W'(6);
      ST_LEN:        field_bytes = CNT_W'(2);
      ST_JAM:        field_bytes = CNT_W'(JAM_BYTES);
      default:       is_field    = 1'b0;
    endcase
  end

  // Nibble beats take two beats per byte.
  assign field_beats = gmii_mode_i ? field_bytes : {field_bytes[CNT_W-2:0], 1'b0};
  assign field_done  = is_field & (beat_q == field_beats - CNT_ONE);
  assign exc_defer   = st_defer & (beat_q == CNT_W'(DEFER_LIMIT)) & ~ex_dfr_en_i;

  // Widened by two bits so the +15 cannot overflow and MinFL-4 can be guarded.
  assign min_lhs = {2'b00, byte_q} + (CNT_W+2)'(15);
  assign min_rhs = {2'b00, min_fl_i} - (CNT_W+2)'(4);

  always_comb begin
    beat_d = beat_q;
    if (st_idle | state_start_i | field_done | (st_defer & exc_defer & ~tx_start_frm_i))
      beat_d = '0;
    else if (!st_idle && !(st_defer && exc_defer) && beat_q != CNT_MAX)
      beat_d = beat_q + CNT_ONE;
  end

  always_comb begin
    byte_d = byte_q;
    if (start_backoff_i | (st_idle & tx_start_frm_i) | packet_finished_i)
      byte_d = '0;
    else if (((tx_state_i == ST_DATA || tx_state_i == ST_PAD || tx_state_i == ST_FCS) && byte_strobe) ||
             (st_backoff && beat_q[6:0] == 7'h7F)) begin
      if (byte_q != CNT_MAX) byte_d = byte_q + CNT_ONE;
    end
  end

  always_comb begin
    dly_d = dly_q;
    if (start_jam_i | packet_finished_i | (st_data & (dly_q == 3'(DLYCRC_LEN))))
      dly_d = '0;
    else if (dly_crc_en_i & ((st_sfd & byte_strobe) | (st_data & byte_strobe & (dly_q != 3'd0))))
      dly_d = dly_q + 3'd1;
  end

  always_comb begin
    frame_d    = frame_q;
    last_len_d = last_len_q;
    if (packet_finished_i & ~frame_aborted_i) begin
      frame_d    = frame_q + STAT_ONE;
      last_len_d = byte_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q     <= '0;
      byte_q     <= '0;
      dly_q      <= '0;
      frame_q    <= '0;
      last_len_q <= '0;
    end else begin
      beat_q     <= beat_d;
      byte_q     <= byte_d;
      dly_q      <= dly_d;
      frame_q    <= frame_d;
      last_len_q <= last_len_d;
    end
  end

  assign beat_cnt_o        = beat_q;
  assign byte_cnt_o        = byte_q;
  assign field_done_o      = field_done;
  assign excessive_defer_o = exc_defer;
  assign max_frame_o       = (byte_q == max_fl_i) & ~hug_en_i;
  assign min_frame_met_o   = (min_fl_i < CNT_W'(4)) | (min_lhs >= min_rhs);
  assign dly_crc_cnt_o     = dly_q;
  assign frame_cnt_o       = frame_q;
  assign last_len_o        = last_len_q;

endmodule
